// File: rtl/tdm_demux_4ch.sv
// Receive-side 4-slot TDM demultiplexer: samples a shared bit bus on enabled
// cycles, aligns to slot 0 on sync, and emits one 4-bit word per frame.
module tdm_demux_4ch #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_in,
  input  logic             bus_en,
  input  logic             sync,
  output logic [3:0]       data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic [1:0]       slot,
  output logic             locked,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0] state;
  logic [2:0] partial;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      slot       <= 2'd0;
      partial    <= 3'b000;
      data_out   <= 4'b0000;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      // bus_in is only meaningful while the transmitter drives the bus
      if (bus_en) begin
        case (state)
          IDLE: begin
            if (sync) begin
              partial <= {2'b00, bus_in};
              slot    <= 2'd1;
              state   <= RUN;
              locked  <= 1'b1;
            end
          end
          default: begin
            if (sync && slot != 2'd0) begin
              // misaligned sync: drop the partial frame and restart at slot 0
              frame_err <= 1'b1;
              partial   <= {2'b00, bus_in};
              slot      <= 2'd1;
            end else begin
              case (slot)
                2'd0: begin partial[0] <= bus_in; slot <= 2'd1; end
                2'd1: begin partial[1] <= bus_in; slot <= 2'd2; end
                2'd2: begin partial[2] <= bus_in; slot <= 2'd3; end
                default: begin
                  data_out   <= {bus_in, partial};
                  data_valid <= 1'b1;
                  frame_cnt  <= frame_cnt + CNT_W'(1);
                  slot       <= 2'd0;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule
